shooter_status_ctrl: RTL and testbench

// - Downstream consumer of the collision stage. Registers the combinational hit flags
//   (shooter_take_damage, zombie_dead[9:0]) into persistent game state.
// - Maintains shooter health with a frame-timed invulnerability window and a saturating
//   4-digit BCD kill score.
// - Runs the IDLE/PLAY/OVER game FSM. Drives the HUD/score renderer and the zombie spawner.

---
 rtl/game_pkg.sv | 13 +
 rtl/bcd_sat_accum.sv | 51 +++++
 rtl/shooter_status_ctrl.sv | 117 +++++++++++
 tb/tb_shooter_status_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-state types and constants for the shooter status/score logic.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_OVER = 2'd2
  } game_state_t;

  localparam int          NUM_ZOMBIES = 10;
  localparam logic [15:0] BCD_MAX     = 16'h9999;

endpackage

// File: rtl/bcd_sat_accum.sv
// Four-digit BCD accumulator. Adds a 0..15 increment with digit-wise carry
// and clamps at 9999.
module bcd_sat_accum
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  add,
  output logic [15:0] bcd
);

  logic [15:0] addend;
  logic [15:0] sum;
  logic [4:0]  carry;

  // Split the binary increment into tens/ones so it can ride the BCD adder chain.
  always_comb begin
    addend = 16'h0000;
    if (add >= 4'd10) begin
      addend[7:4] = 4'd1;
      addend[3:0] = add - 4'd10;
    end else begin
      addend[3:0] = add;
    end
  end

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] raw;
      assign raw = {1'b0, bcd[gi*4 +: 4]} + {1'b0, addend[gi*4 +: 4]} + {4'b0000, carry[gi]};
      assign sum[gi*4 +: 4] = (raw > 5'd9) ? 4'(raw - 5'd10) : raw[3:0];
      assign carry[gi+1]    = (raw > 5'd9);
    end
  endgenerate

  // A carry out of the thousands digit means the true sum passed 9999.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd <= 16'h0000;
    end else if (clr) begin
      bcd <= 16'h0000;
    end else if (en) begin
      bcd <= carry[4] ? BCD_MAX : sum;
    end
  end

endmodule

// File: rtl/shooter_status_ctrl.sv
// Game state owner: IDLE/PLAY/OVER FSM, shooter health with frame-timed
// invulnerability, kill edge detection and the BCD kill score.
module shooter_status_ctrl
  import game_pkg::*;
#(
  parameter int MAX_HEALTH  = 3,
  parameter int IFRAMES     = 60,
  parameter int NUM_ZOMBIES = 10
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   shooter_take_damage,
  input  logic [NUM_ZOMBIES-1:0] zombie_dead,
  output logic [2:0]             health,
  output logic                   invincible,
  output logic [15:0]            score_bcd,
  output game_state_t            game_state,
  output logic                   game_over,
  output logic [NUM_ZOMBIES-1:0] kill_pulse
);

  localparam logic [2:0] HEALTH_INIT = 3'(MAX_HEALTH);
  localparam logic [7:0] IFRAME_LOAD = 8'(IFRAMES);

  logic                   start_q;
  logic                   start_rise;
  logic                   in_play;
  logic                   hit;
  logic                   score_clr;
  logic                   score_en;
  logic [7:0]             iframe_cnt;
  logic [NUM_ZOMBIES-1:0] dead_q;
  logic [NUM_ZOMBIES-1:0] new_kills;
  logic [3:0]             kill_count;

  always_comb begin
    in_play    = (game_state == GS_PLAY);
    start_rise = start & ~start_q;
    hit        = in_play & shooter_take_damage & (iframe_cnt == 8'd0) & (health != 3'd0);
    new_kills  = zombie_dead & ~dead_q;
    score_clr  = (game_state == GS_IDLE) & start_rise;
    // kill_pulse can only be nonzero one cycle after PLAY, so kills landing
    // on the PLAY->OVER edge still drain into the score.
    score_en   = |kill_pulse;
    kill_count = 4'd0;
    for (int i = 0; i < NUM_ZOMBIES; i++) begin
      kill_count = kill_count + 4'(kill_pulse[i]);
    end
  end

  bcd_sat_accum u_score (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (score_clr),
    .en      (score_en),
    .add     (kill_count),
    .bcd     (score_bcd)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      game_state <= GS_IDLE;
      health     <= HEALTH_INIT;
      iframe_cnt <= 8'd0;
      invincible <= 1'b0;
      game_over  <= 1'b0;
      kill_pulse <= '0;
      dead_q     <= '0;
      start_q    <= 1'b0;
    end else begin
      start_q    <= start;
      dead_q     <= zombie_dead;
      kill_pulse <= in_play ? new_kills : '0;
      case (game_state)
        GS_IDLE: begin
          if (start_rise) begin
            game_state <= GS_PLAY;
            health     <= HEALTH_INIT;
            iframe_cnt <= 8'd0;
            invincible <= 1'b0;
          end
        end
        GS_PLAY: begin
          // A hit reloads the window even when a frame tick lands on the same edge.
          if (hit) begin
            health <= health - 3'd1;
            if (health == 3'd1) begin
              game_state <= GS_OVER;
              game_over  <= 1'b1;
              iframe_cnt <= 8'd0;
              invincible <= 1'b0;
            end else begin
              iframe_cnt <= IFRAME_LOAD;
              invincible <= 1'b1;
            end
          end else if (frame_tick && (iframe_cnt != 8'd0)) begin
            iframe_cnt <= iframe_cnt - 8'd1;
            invincible <= (iframe_cnt != 8'd1);
          end
        end
        GS_OVER: begin
          if (start_rise) begin
            game_state <= GS_IDLE;
            game_over  <= 1'b0;
          end
        end
        default: begin
          game_state <= GS_IDLE;
          game_over  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shooter_status_ctrl.sv
// Self-checking bench for shooter_status_ctrl: directed scenarios plus random
// play compared against an integer-level game model.
module tb_shooter_status_ctrl;

  localparam int MAXH = 3;
  localparam int IFR  = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ft = 1'b0;
  logic        start = 1'b0;
  logic        dmg = 1'b0;
  logic [9:0]  zd = '0;
  logic [2:0]  health;
  logic        invincible;
  logic [15:0] score_bcd;
  logic [1:0]  gs;
  logic        game_over;
  logic [9:0]  kill_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, 0=IDLE 1=PLAY 2=OVER.
  int         m_state, m_health, m_iframe, m_score;
  logic [9:0] m_kill, m_dead_q;
  logic       m_start_q;

  shooter_status_ctrl #(.MAX_HEALTH(MAXH), .IFRAMES(IFR), .NUM_ZOMBIES(10)) dut (
    .Clk                 (clk),
    .Reset_n             (rst_n),
    .frame_tick          (ft),
    .start               (start),
    .shooter_take_damage (dmg),
    .zombie_dead         (zd),
    .health              (health),
    .invincible          (invincible),
    .score_bcd           (score_bcd),
    .game_state          (gs),
    .game_over           (game_over),
    .kill_pulse          (kill_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_health = MAXH; m_iframe = 0; m_score = 0;
    m_kill = '0; m_dead_q = '0; m_start_q = 1'b0;
  endtask

  // One clock edge of game rules, from the inputs currently applied.
  task automatic model_step();
    bit         rise;
    logic [9:0] nk;
    rise = start && !m_start_q;
    if (m_kill != 0) begin
      m_score = m_score + $countones(m_kill);
      if (m_score > 9999) m_score = 9999;
    end
    nk = (m_state == 1) ? (zd & ~m_dead_q) : '0;
    if (m_state == 0) begin
      if (rise) begin
        m_state = 1; m_health = MAXH; m_iframe = 0; m_score = 0;
      end
    end else if (m_state == 1) begin
      if (dmg && m_iframe == 0 && m_health > 0) begin
        m_health = m_health - 1;
        if (m_health == 0) begin
          m_state = 2; m_iframe = 0;
        end else begin
          m_iframe = IFR;
        end
      end else if (ft && m_iframe > 0) begin
        m_iframe = m_iframe - 1;
      end
    end else begin
      if (rise) m_state = 0;
    end
    m_kill = nk; m_dead_q = zd; m_start_q = start;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; dmg = 0; ft = 0; zd = '0;
    rst_n = 0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic go_play();
    start = 1; tick();
    start = 0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", gs); end
    checks++; if (health !== 3'd3) begin errors++; $display("FAIL reset_health got %0d exp 3", health); end
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL reset_inv got %0b exp 0", invincible); end
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got %h exp 0000", score_bcd); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %0b exp 0", game_over); end
    checks++; if (kill_pulse !== 10'h000) begin errors++; $display("FAIL reset_kill got %h exp 000", kill_pulse); end
  endtask

  task automatic test_start();
    start = 1;
    tick();
    checks++; if (gs !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", gs); end
    checks++; if (health !== 3'd3) begin errors++; $display("FAIL start_health got %0d exp 3", health); end
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL start_score got %h exp 0000", score_bcd); end
    start = 0;
    tick();
  endtask

  task automatic test_single_kill();
    int pulses = 0;
    int first = -1;
    zd = 10'h010;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (kill_pulse[4] === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      checks++; if (kill_pulse !== m_kill) begin errors++; $display("FAIL kill4_pulse got %h exp %h", kill_pulse, m_kill); end
      if (i == 1) begin
        checks++; if (score_bcd !== 16'h0001) begin errors++; $display("FAIL kill4_score got %h exp 0001", score_bcd); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL kill4_count got %0d exp 1", pulses); end
    checks++; if (first != 0) begin errors++; $display("FAIL kill4_latency got %0d exp 0", first); end
    zd = '0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    go_play();
    for (int i = 0; i < 999; i++) begin
      zd = 10'h3FF; tick();
      zd = 10'h000; tick();
      if (i == 9) begin
        checks++; if (score_bcd !== 16'h0100) begin errors++; $display("FAIL sat_carry got %h exp 0100", score_bcd); end
      end
    end
    zd = 10'h01F; tick();
    zd = 10'h000; tick();
    checks++; if (score_bcd !== 16'h9995) begin errors++; $display("FAIL sat_pre got %h exp 9995", score_bcd); end
    zd = 10'h3FF; tick();
    checks++; if (kill_pulse !== 10'h3FF) begin errors++; $display("FAIL sat_pulses got %h exp 3ff", kill_pulse); end
    zd = 10'h000; tick();
    checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_clamp got %h exp 9999", score_bcd); end
    zd = 10'h3FF; tick();
    zd = 10'h000; tick();
    checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_hold got %h exp 9999", score_bcd); end
    checks++; if (score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL sat_model got %h exp %h", score_bcd, to_bcd(m_score)); end
  endtask

  task automatic test_damage();
    int   ticks = 0;
    bit   prev_ft = 0;
    bit   done = 0;
    logic [2:0] ph;
    do_reset();
    go_play();
    dmg = 1; ft = 0;
    tick();
    checks++; if (health !== 3'd2) begin errors++; $display("FAIL dmg_first got %0d exp 2", health); end
    checks++; if (invincible !== 1'b1) begin errors++; $display("FAIL dmg_inv got %0b exp 1", invincible); end
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      ft = (cyc % 4 == 3);
      ph = health;
      tick();
      checks++; if (health !== 3'(m_health)) begin errors++; $display("FAIL dmg_model got %0d exp %0d", health, m_health); end
      if (health != ph) begin
        checks++;
        if (ticks != IFR || !prev_ft) begin errors++; $display("FAIL dmg_spacing got %0d ticks exp %0d", ticks, IFR); end
        ticks = 0;
        if (health == 3'd0) begin
          done = 1;
          checks++; if (gs !== 2'd2) begin errors++; $display("FAIL dmg_over_state got %0d exp 2", gs); end
          checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL dmg_over_flag got %0b exp 1", game_over); end
          checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL dmg_over_inv got %0b exp 0", invincible); end
        end
      end else if (ft) begin
        ticks++;
      end
      prev_ft = ft;
    end
    checks++; if (!done) begin errors++; $display("FAIL dmg_timeout got health %0d exp 0", health); end
    dmg = 0; ft = 0;
  endtask

  task automatic test_load_wins();
    do_reset();
    go_play();
    dmg = 1; ft = 1;
    tick();
    dmg = 0;
    checks++; if (health !== 3'd2) begin errors++; $display("FAIL lw_health got %0d exp 2", health); end
    checks++; if (invincible !== 1'b1) begin errors++; $display("FAIL lw_inv got %0b exp 1", invincible); end
    for (int i = 0; i < IFR - 1; i++) tick();
    checks++; if (invincible !== 1'b1) begin errors++; $display("FAIL lw_inv59 got %0b exp 1", invincible); end
    tick();
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL lw_inv60 got %0b exp 0", invincible); end
    checks++; if (health !== 3'd2) begin errors++; $display("FAIL lw_once got %0d exp 2", health); end
    ft = 0;
  endtask

  task automatic test_over();
    int guard = 0;
    do_reset();
    go_play();
    zd = 10'h003; tick();
    zd = 10'h000; tick(); tick();
    dmg = 1; ft = 1;
    while (gs !== 2'd2 && guard < 500) begin tick(); guard++; end
    checks++; if (gs !== 2'd2) begin errors++; $display("FAIL over_reach got %0d exp 2", gs); end
    for (int i = 0; i < 10; i++) begin
      zd = (i % 2 == 0) ? 10'h3FF : 10'h000;
      tick();
      checks++; if (kill_pulse !== 10'h000) begin errors++; $display("FAIL over_kill got %h exp 000", kill_pulse); end
    end
    checks++; if (score_bcd !== 16'h0002) begin errors++; $display("FAIL over_score got %h exp 0002", score_bcd); end
    checks++; if (health !== 3'd0) begin errors++; $display("FAIL over_health got %0d exp 0", health); end
    dmg = 0; ft = 0; zd = '0;
    start = 1; tick();
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL over_idle got %0d exp 0", gs); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_flag got %0b exp 0", game_over); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL over_nochain got %0d exp 0", gs); end
    checks++; if (score_bcd !== 16'h0002 || health !== 3'd0) begin errors++; $display("FAIL over_hold got %h/%0d exp 0002/0", score_bcd, health); end
    start = 0; tick();
    start = 1; tick();
    checks++; if (gs !== 2'd1 || health !== 3'd3 || score_bcd !== 16'h0000) begin
      errors++; $display("FAIL over_restart got %0d/%0d/%h exp 1/3/0000", gs, health, score_bcd);
    end
    start = 0; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    go_play();
    zd = 10'h001; tick();
    zd = 10'h000; tick();
    dmg = 1; zd = 10'h006; tick();
    dmg = 0;
    #2;
    rst_n = 0;
    #1;
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", gs); end
    checks++; if (health !== 3'd3) begin errors++; $display("FAIL mid_health got %0d exp 3", health); end
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL mid_inv got %0b exp 0", invincible); end
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL mid_score got %h exp 0000", score_bcd); end
    checks++; if (kill_pulse !== 10'h000) begin errors++; $display("FAIL mid_kill got %h exp 000", kill_pulse); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL mid_over got %0b exp 0", game_over); end
    zd = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      dmg = ($urandom_range(0, 5) == 0);
      ft  = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 7) == 0) zd[b] = ~zd[b];
      tick();
      checks++; if (gs !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", i, gs, m_state); end
      checks++; if (health !== 3'(m_health)) begin errors++; $display("FAIL rnd_health cyc %0d got %0d exp %0d", i, health, m_health); end
      checks++; if (invincible !== (m_iframe != 0)) begin errors++; $display("FAIL rnd_inv cyc %0d got %0b exp %0b", i, invincible, m_iframe != 0); end
      checks++; if (score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL rnd_score cyc %0d got %h exp %h", i, score_bcd, to_bcd(m_score)); end
      checks++; if (game_over !== (m_state == 2)) begin errors++; $display("FAIL rnd_over cyc %0d got %0b exp %0b", i, game_over, m_state == 2); end
      checks++; if (kill_pulse !== m_kill) begin errors++; $display("FAIL rnd_kill cyc %0d got %h exp %h", i, kill_pulse, m_kill); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_single_kill();
    test_saturation();
    test_damage();
    test_load_wins();
    test_over();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
